// File: rtl/isp_awb_gain_calc_if.sv
// Statistics-in / gains-out bundle of the gray-world AWB gain calculator.
// The master side is the statistics stage; the slave side is the gain calculator.
interface isp_awb_gain_calc_if #(
   parameter int OUT_BITS  = 32,
   parameter int GAIN_BITS = 8
);
   logic                 in_done;
   logic [OUT_BITS-1:0]  in_cnt;
   logic [OUT_BITS-1:0]  in_sum_r;
   logic [OUT_BITS-1:0]  in_sum_g;
   logic [OUT_BITS-1:0]  in_sum_b;
   logic [GAIN_BITS-1:0] out_r_gain;
   logic [GAIN_BITS-1:0] out_b_gain;
   logic                 out_valid;
   logic                 out_skip;
   logic                 out_busy;

   modport master (
      output in_done, in_cnt, in_sum_r, in_sum_g, in_sum_b,
      input  out_r_gain, out_b_gain, out_valid, out_skip, out_busy
   );

   modport slave (
      input  in_done, in_cnt, in_sum_r, in_sum_g, in_sum_b,
      output out_r_gain, out_b_gain, out_valid, out_skip, out_busy
   );
endinterface

// File: rtl/isp_awb_gain_calc.sv
// Gray-world white-balance gain calculator: R and B gains relative to G,
// computed by a shared restoring divider, then damped and saturated.
module isp_awb_gain_calc #(
   parameter int OUT_BITS  = 32,
   parameter int GAIN_BITS = 8,
   parameter int GAIN_FRAC = 4
) (
   input  logic                pclk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [1:0]          damp,
   input  logic [OUT_BITS-1:0] min_cnt,
   isp_awb_gain_calc_if.slave  bus
);
   localparam int N  = OUT_BITS + GAIN_FRAC;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0]        LAST  = CW'(N - 1);
   localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1) << GAIN_FRAC;

   typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

   state_t               state;
   logic [OUT_BITS-1:0]  sum_r, sum_g, sum_b;
   logic [N-1:0]         dvd;
   logic [N-2:0]         quo;
   logic [OUT_BITS-1:0]  rem;
   logic [CW-1:0]        iter;
   logic [1:0]           damp_q;
   logic [GAIN_BITS-1:0] r_gain, b_gain, tgt_r, tgt_b;
   logic                 valid_q, skip_q, busy_q;

   logic [OUT_BITS-1:0]  divisor;
   logic [OUT_BITS:0]    rem_sh;
   logic                 q_bit;
   logic [OUT_BITS-1:0]  rem_next;
   logic [N-1:0]         quo_next;
   logic [GAIN_BITS-1:0] tgt_next;

   // One restoring-division step; tgt_next is only meaningful on the last step.
   always_comb begin
      divisor  = (state == DIV_B) ? sum_b : sum_r;
      rem_sh   = {rem, dvd[N-1]};
      q_bit    = (rem_sh >= {1'b0, divisor});
      rem_next = q_bit ? OUT_BITS'(rem_sh - {1'b0, divisor}) : rem_sh[OUT_BITS-1:0];
      quo_next = {quo, q_bit};
      if ((divisor == '0) || (|quo_next[N-1:GAIN_BITS]))
         tgt_next = '1;
      else
         tgt_next = quo_next[GAIN_BITS-1:0];
   end

   function automatic logic [GAIN_BITS-1:0] damped(input logic [GAIN_BITS-1:0] old,
                                                   input logic [GAIN_BITS-1:0] tgt,
                                                   input logic [1:0]           sh);
      logic signed [GAIN_BITS:0] diff;
      logic signed [GAIN_BITS:0] step;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, old});
      step = diff >>> sh;
      return GAIN_BITS'($signed({1'b0, old}) + step);
   endfunction

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sum_r   <= '0;
         sum_g   <= '0;
         sum_b   <= '0;
         dvd     <= '0;
         quo     <= '0;
         rem     <= '0;
         iter    <= '0;
         damp_q  <= '0;
         tgt_r   <= '0;
         tgt_b   <= '0;
         r_gain  <= UNITY;
         b_gain  <= UNITY;
         valid_q <= 1'b0;
         skip_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         skip_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_done && enable) begin
                  if (bus.in_cnt < min_cnt) begin
                     skip_q <= 1'b1;
                  end else begin
                     sum_r  <= bus.in_sum_r;
                     sum_g  <= bus.in_sum_g;
                     sum_b  <= bus.in_sum_b;
                     damp_q <= damp;
                     dvd    <= N'(bus.in_sum_g) << GAIN_FRAC;
                     quo    <= '0;
                     rem    <= '0;
                     iter   <= '0;
                     busy_q <= 1'b1;
                     state  <= DIV_R;
                  end
               end
            end
            DIV_R, DIV_B: begin
               rem  <= rem_next;
               quo  <= quo_next[N-2:0];
               dvd  <= {dvd[N-2:0], 1'b0};
               iter <= iter + CW'(1);
               // The divider is reloaded with the G dividend between the R and B passes.
               if (iter == LAST) begin
                  iter <= '0;
                  rem  <= '0;
                  quo  <= '0;
                  if (state == DIV_R) begin
                     tgt_r <= tgt_next;
                     dvd   <= N'(sum_g) << GAIN_FRAC;
                     state <= DIV_B;
                  end else begin
                     tgt_b <= tgt_next;
                     state <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               r_gain  <= damped(r_gain, tgt_r, damp_q);
               b_gain  <= damped(b_gain, tgt_b, damp_q);
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_r_gain = r_gain;
   assign bus.out_b_gain = b_gain;
   assign bus.out_valid  = valid_q;
   assign bus.out_skip   = skip_q;
   assign bus.out_busy   = busy_q;
endmodule

// File: tb/tb_isp_awb_gain_calc.sv
// Directed plus randomized bench for isp_awb_gain_calc against an arithmetic
// gray-world reference model (integer division, floor-rounded damping).
module tb_isp_awb_gain_calc;
   localparam int OUT_BITS  = 32;
   localparam int GAIN_BITS = 8;
   localparam int GAIN_FRAC = 4;
   localparam int LAT       = 2 * (OUT_BITS + GAIN_FRAC) + 2;
   localparam int UNITY     = 2 ** GAIN_FRAC;
   localparam int GMAX      = 2 ** GAIN_BITS - 1;

   logic                pclk = 1'b0;
   logic                rst_n = 1'b0;
   logic                enable = 1'b1;
   logic [1:0]          damp = 2'd0;
   logic [OUT_BITS-1:0] min_cnt = 1;

   int          checks = 0;
   int          errors = 0;
   int unsigned model_r = UNITY;
   int unsigned model_b = UNITY;

   isp_awb_gain_calc_if #(.OUT_BITS(OUT_BITS), .GAIN_BITS(GAIN_BITS)) bus ();

   isp_awb_gain_calc #(.OUT_BITS(OUT_BITS), .GAIN_BITS(GAIN_BITS), .GAIN_FRAC(GAIN_FRAC)) dut (
      .pclk    (pclk),
      .rst_n   (rst_n),
      .enable  (enable),
      .damp    (damp),
      .min_cnt (min_cnt),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned ref_target(input longint unsigned num, input longint unsigned den);
      longint unsigned q;
      if (den == 0) return GMAX;
      q = (num * UNITY) / den;
      return (q > GMAX) ? GMAX : int'(q);
   endfunction

   function automatic int unsigned ref_damp(input int unsigned old, input int unsigned tgt,
                                            input int unsigned d);
      int diff, dv, step;
      diff = int'(tgt) - int'(old);
      dv   = 1 << d;
      if (diff >= 0) step = diff / dv;
      else           step = -((-diff + dv - 1) / dv);
      return int'(old) + step;
   endfunction

   // Pulses in_done for one cycle, then scrambles the statistics; returns in cycle 1.
   task automatic start(input logic [31:0] c, input logic [31:0] r, input logic [31:0] g,
                        input logic [31:0] b);
      @(negedge pclk);
      bus.in_done  = 1'b1;
      bus.in_cnt   = c;
      bus.in_sum_r = r;
      bus.in_sum_g = g;
      bus.in_sum_b = b;
      @(negedge pclk);
      bus.in_done  = 1'b0;
      bus.in_cnt   = $urandom();
      bus.in_sum_r = $urandom();
      bus.in_sum_g = $urandom();
      bus.in_sum_b = $urandom();
   endtask

   task automatic frame_ok(input string tag, input logic [31:0] c, input logic [31:0] r,
                           input logic [31:0] g, input logic [31:0] b, input int extra_cyc);
      int unsigned er, eb;
      int vcyc, busy_err, hold_err;
      er = ref_damp(model_r, ref_target(g, r), damp);
      eb = ref_damp(model_b, ref_target(g, b), damp);
      vcyc = 0; busy_err = 0; hold_err = 0;
      start(c, r, g, b);
      for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
         if (cyc > 1) @(negedge pclk);
         if (cyc == extra_cyc) begin
            bus.in_done  = 1'b1;
            bus.in_cnt   = '1;
            bus.in_sum_r = $urandom_range(1, 1000);
            bus.in_sum_g = $urandom();
            bus.in_sum_b = $urandom_range(1, 1000);
         end else begin
            bus.in_done = 1'b0;
         end
         if (bus.out_busy !== (cyc < LAT)) busy_err++;
         if (bus.out_valid === 1'b1) begin
            vcyc = cyc;
            break;
         end
         if (bus.out_r_gain !== GAIN_BITS'(model_r) || bus.out_b_gain !== GAIN_BITS'(model_b))
            hold_err++;
      end
      check({tag, " valid_cycle"}, vcyc, LAT);
      check({tag, " busy_window"}, busy_err, 0);
      check({tag, " gain_hold"}, hold_err, 0);
      check({tag, " r_gain"}, bus.out_r_gain, er);
      check({tag, " b_gain"}, bus.out_b_gain, eb);
      model_r = er;
      model_b = eb;
      @(negedge pclk);
      check({tag, " valid_pulse_end"}, {bus.out_valid, bus.out_busy}, 2'b00);
   endtask

   task automatic frame_skip(input string tag, input logic [31:0] c, input bit expect_skip);
      int skip_n, first_skip, valid_n, busy_n;
      skip_n = 0; first_skip = 0; valid_n = 0; busy_n = 0;
      start(c, 32'd1000, 32'd500000, 32'd2000);
      for (int cyc = 1; cyc <= LAT + 10; cyc++) begin
         if (cyc > 1) @(negedge pclk);
         if (bus.out_skip === 1'b1) begin
            skip_n++;
            if (first_skip == 0) first_skip = cyc;
         end
         if (bus.out_valid !== 1'b0) valid_n++;
         if (bus.out_busy !== 1'b0) busy_n++;
      end
      check({tag, " skip_count"}, skip_n, expect_skip ? 1 : 0);
      check({tag, " skip_cycle"}, first_skip, expect_skip ? 1 : 0);
      check({tag, " no_valid"}, valid_n, 0);
      check({tag, " no_busy"}, busy_n, 0);
      check({tag, " gains_kept"}, {bus.out_r_gain, bus.out_b_gain},
            {GAIN_BITS'(model_r), GAIN_BITS'(model_b)});
   endtask

   initial begin
      int valid_n, busy_n;
      logic [31:0] rr, gg, bb;
      bus.in_done  = 1'b0;
      bus.in_cnt   = '0;
      bus.in_sum_r = '0;
      bus.in_sum_g = '0;
      bus.in_sum_b = '0;

      repeat (3) @(negedge pclk);
      check("reset r_gain", bus.out_r_gain, UNITY);
      check("reset b_gain", bus.out_b_gain, UNITY);
      check("reset flags", {bus.out_valid, bus.out_skip, bus.out_busy}, 3'b000);
      rst_n = 1'b1;

      frame_ok("gray", 1000, 128000, 128000, 128000, 0);
      check("gray r16", bus.out_r_gain, 16);
      frame_ok("cast", 1000, 100000, 200000, 400000, 0);
      check("cast r32 b8", {bus.out_r_gain, bus.out_b_gain}, {8'd32, 8'd8});
      frame_ok("sat", 1000, 0, 1000000, 1000, 0);
      check("sat 255", {bus.out_r_gain, bus.out_b_gain}, {8'd255, 8'd255});

      min_cnt = 100;
      frame_skip("reject", 50, 1'b1);
      frame_skip("min_cnt_edge_below", 99, 1'b1);
      enable = 1'b0;
      frame_skip("disabled", 1000, 1'b0);
      enable = 1'b1;
      frame_ok("min_cnt_equal", 100, 128000, 128000, 128000, 0);
      min_cnt = 1;

      damp = 2'd2;
      frame_ok("damp1", 1000, 100000, 300000, 100000, 0);
      check("damp seq 24", bus.out_r_gain, 24);
      frame_ok("damp2", 1000, 100000, 300000, 100000, 0);
      check("damp seq 30", bus.out_b_gain, 30);
      frame_ok("damp3", 1000, 100000, 300000, 100000, 0);
      check("damp seq 34", bus.out_r_gain, 34);
      repeat (4) frame_ok("damp_conv", 1000, 100000, 300000, 100000, 0);
      damp = 2'd0;
      frame_ok("unity", 1000, 128000, 128000, 128000, 0);
      damp = 2'd2;
      frame_ok("damp_down", 1000, 160000, 150000, 160000, 0);
      check("damp down to 15", {bus.out_r_gain, bus.out_b_gain}, {8'd15, 8'd15});

      damp = 2'd0;
      frame_ok("busy_ignore", 1000, 100000, 200000, 400000, 10);

      start(1000, 1000, 5000000, 3000);
      repeat (39) @(negedge pclk);
      rst_n = 1'b0;
      #1;
      check("midreset gains", {bus.out_r_gain, bus.out_b_gain}, {8'd16, 8'd16});
      check("midreset flags", {bus.out_valid, bus.out_skip, bus.out_busy}, 3'b000);
      model_r = UNITY;
      model_b = UNITY;
      @(negedge pclk);
      rst_n = 1'b1;
      valid_n = 0; busy_n = 0;
      repeat (LAT + 10) begin
         @(negedge pclk);
         if (bus.out_valid !== 1'b0) valid_n++;
         if (bus.out_busy !== 1'b0) busy_n++;
      end
      check("midreset no_valid", valid_n, 0);
      check("midreset no_busy", busy_n, 0);

      for (int i = 0; i < 10; i++) begin
         damp = 2'($urandom_range(0, 3));
         gg = $urandom() >> $urandom_range(0, 12);
         rr = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 16));
         bb = ($urandom_range(0, 7) == 0) ? 32'd0 : (gg >> $urandom_range(0, 5)) + $urandom_range(0, 999);
         frame_ok("random", $urandom_range(1, 100000), rr, gg, bb, 0);
      end
      min_cnt = 32'd5000;
      frame_skip("random_reject", $urandom_range(0, 4999), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
